// File: rtl/fft_reorder_out_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_out_if
// Description : Stream bundle for the FFT output reorder buffer. Carries the
//               two-path input pair stream and the serialized output stream.
//               The slave modport is the reorder buffer, master is the
//               surrounding logic that feeds pairs and consumes samples.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_reorder_out_if #(
  parameter int WIDTH = 9
);
  // two-path input side
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_up_re;
  logic signed [WIDTH-1:0] in_up_im;
  logic signed [WIDTH-1:0] in_l_re;
  logic signed [WIDTH-1:0] in_l_im;
  // serialized output side
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;
  logic [4:0]              out_index;
  logic                    out_last;

  modport slave (
    input  in_valid, in_up_re, in_up_im, in_l_re, in_l_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last
  );

  modport master (
    output in_valid, in_up_re, in_up_im, in_l_re, in_l_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last
  );
endinterface
`default_nettype wire

// File: rtl/fft_reorder_out.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_out
// Description : Output reorder buffer for the 32-point radix-2 MDC FFT.
//               Accepts bit-reversed bin pairs (Up carries bin b, L carries
//               b+16) into one of two 32-entry ping-pong banks and drains the
//               other bank one complex sample per cycle.
//               Build option FFT_REORDER_BITREV_EN: when defined the drain is
//               in natural bin order 0..31; when undefined the drain reads
//               address bitrev5(rd_cnt), reproducing arrival order serialized.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_out #(
  parameter int WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  fft_reorder_out_if.slave   bus
);

  localparam int ENTRY_W = 2 * WIDTH;

  function automatic logic [4:0] bitrev5(input logic [4:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // storage: re in the upper half, im in the lower half of each entry
  logic [ENTRY_W-1:0] mem [2][32];

  logic [1:0]  full;
  logic [1:0]  full_next;
  logic        wr_bank;
  logic        rd_bank;
  logic [3:0]  in_cnt;
  logic [4:0]  rd_cnt;

  logic                    valid;
  logic                    last;
  logic signed [WIDTH-1:0] re;
  logic signed [WIDTH-1:0] im;
  logic [4:0]              index;

  logic               accept;
  logic               frame_in_done;
  logic               reg_free;
  logic               load;
  logic               frame_out_done;
  logic [4:0]         wr_lo;
  logic [4:0]         wr_hi;
  logic [4:0]         rd_addr;
  logic [ENTRY_W-1:0] rd_word;

  // pair c carries bin bitrev5(2c): bit 4 is always 0 on Up, so L is the same
  // address with bit 4 set
  assign wr_lo = {1'b0, in_cnt[0], in_cnt[1], in_cnt[2], in_cnt[3]};
  assign wr_hi = {1'b1, in_cnt[0], in_cnt[1], in_cnt[2], in_cnt[3]};

  assign accept        = bus.in_valid && !full[wr_bank];
  assign frame_in_done = accept && (in_cnt == 4'd15);

  assign reg_free       = !valid || bus.out_ready;
  assign load           = reg_free && full[rd_bank];
  assign frame_out_done = load && (rd_cnt == 5'd31);

`ifdef FFT_REORDER_BITREV_EN
  assign rd_addr = rd_cnt;
`else
  assign rd_addr = bitrev5(rd_cnt);
`endif

  assign rd_word = mem[rd_bank][rd_addr];

  // set and clear target different banks whenever both fire, so apply both
  always_comb begin
    full_next = full;
    if (frame_in_done)  full_next[wr_bank] = 1'b1;
    if (frame_out_done) full_next[rd_bank] = 1'b0;
  end

  // bank storage: both paths of an accepted pair land in the same cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][wr_lo] <= {bus.in_up_re, bus.in_up_im};
      mem[wr_bank][wr_hi] <= {bus.in_l_re, bus.in_l_im};
    end
  end

  // fill side: pair counter, write bank pointer and bank-full flags
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt  <= 4'd0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_next;
      if (accept) begin
        in_cnt <= in_cnt + 4'd1;
        if (frame_in_done) wr_bank <= ~wr_bank;
      end
    end
  end

  // drain side: registered output stage with hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= 5'd0;
      rd_bank <= 1'b0;
      valid   <= 1'b0;
      last    <= 1'b0;
      re      <= '0;
      im      <= '0;
      index   <= 5'd0;
    end else if (load) begin
      re     <= rd_word[ENTRY_W-1:WIDTH];
      im     <= rd_word[WIDTH-1:0];
      index  <= rd_addr;
      valid  <= 1'b1;
      last   <= (rd_cnt == 5'd31);
      rd_cnt <= rd_cnt + 5'd1;
      if (frame_out_done) rd_bank <= ~rd_bank;
    end else if (reg_free) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = valid;
  assign bus.out_last  = last;
  assign bus.out_re    = re;
  assign bus.out_im    = im;
  assign bus.out_index = index;

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_reorder_out
// Description : Directed self-checking bench for fft_reorder_out. Expected
//               output order follows FFT_REORDER_BITREV_EN the same way the
//               design does (natural order when defined, bitrev5 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_reorder_out;

  localparam int WIDTH = 9;

  typedef logic [2*WIDTH+5:0] sample_t;  // {re, im, index, last}

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int backpressure = 0;
  int last_acc_cyc = 0;
  int hold_errs    = 0;

  sample_t cap_q[$];
  int      stamp_q[$];

  fft_reorder_out_if #(.WIDTH(WIDTH)) bus ();

  fft_reorder_out #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // free-running cycle stamp
  always @(posedge clk) cyc <= cyc + 1;

  // count cycles where upstream is held off
  always @(negedge clk) if (bus.in_valid && !bus.in_ready) backpressure++;

  function automatic logic [4:0] bitrev5(input logic [4:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // modes 0..3: re = bin + 32*mode, im = -re; mode 4: full-scale extremes
  function automatic logic signed [WIDTH-1:0] data_re(input int mode, input int bin);
    logic signed [WIDTH-1:0] v;
    if (mode == 4) v = (bin % 2 == 1) ? 9'sh0FF : 9'sh100;
    else           v = WIDTH'(bin + 32 * mode);
    return v;
  endfunction

  function automatic logic signed [WIDTH-1:0] data_im(input int mode, input int bin);
    logic signed [WIDTH-1:0] v;
    if (mode == 4) v = (bin % 2 == 1) ? 9'sh100 : 9'sh0FF;
    else           v = -data_re(mode, bin);
    return v;
  endfunction

  function automatic int exp_bin(input int k);
`ifdef FFT_REORDER_BITREV_EN
    return k;
`else
    return int'(bitrev5(5'(k)));
`endif
  endfunction

  function automatic sample_t exp_sample(input int mode, input int k);
    int         b;
    logic [4:0] bb;
    b  = exp_bin(k);
    bb = 5'(b);
    return {data_re(mode, b), data_im(mode, b), bb, (k == 31)};
  endfunction

  // drive pairs first..first+count-1 of a frame, honouring in_ready
  task automatic send_pairs(input int mode, input int first, input int count);
    for (int c = first; c < first + count; c++) begin
      logic [4:0] b;
      bit         acc;
      int         n;
      b   = bitrev5(5'(2 * c));
      acc = 1'b0;
      n   = 0;
      bus.in_valid = 1'b1;
      bus.in_up_re = data_re(mode, int'(b));
      bus.in_up_im = data_im(mode, int'(b));
      bus.in_l_re  = data_re(mode, int'(b) + 16);
      bus.in_l_im  = data_im(mode, int'(b) + 16);
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = bus.in_ready;
        last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) begin
        n_checks++;
        n_fails++;
        $display("FAIL in_accept_timeout pair %0d: in_ready=0 required 1", c);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // record transfers; stall_pct sets the chance of out_ready low per cycle
  task automatic collect(input int n, input int stall_pct, input int budget);
    int      t;
    sample_t prev;
    sample_t cur;
    bit      prev_stall;
    t = 0;
    prev = '0;
    prev_stall = 1'b0;
    cap_q.delete();
    stamp_q.delete();
    hold_errs = 0;
    while (cap_q.size() < n && t < budget) begin
      bus.out_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      cur = {bus.out_re, bus.out_im, bus.out_index, bus.out_last};
      if (prev_stall && (!bus.out_valid || cur !== prev)) hold_errs++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev = cur;
      if (bus.out_valid && bus.out_ready) begin
        cap_q.push_back(cur);
        stamp_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fails++; $display("FAIL reset_out_last: got %b required 0", bus.out_last); end
    n_checks++; if (bus.out_re !== 9'sd0) begin n_fails++; $display("FAIL reset_out_re: got %0d required 0", bus.out_re); end
    n_checks++; if (bus.out_im !== 9'sd0) begin n_fails++; $display("FAIL reset_out_im: got %0d required 0", bus.out_im); end
    n_checks++; if (bus.out_index !== 5'd0) begin n_fails++; $display("FAIL reset_out_index: got %0d required 0", bus.out_index); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_frame;
    int gap_errs;
    gap_errs = 0;
    fork
      send_pairs(0, 0, 16);
      collect(32, 0, 200);
    join
    n_checks++; if (cap_q.size() != 32) begin n_fails++; $display("FAIL single_count: got %0d required 32", cap_q.size()); end
    for (int i = 0; i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_sample(0, i)) begin
        n_fails++;
        $display("FAIL single_sample[%0d]: got %h required %h", i, cap_q[i], exp_sample(0, i));
      end
      if (i > 0 && stamp_q[i] - stamp_q[i-1] != 1) gap_errs++;
    end
    if (stamp_q.size() > 0) begin
      n_checks++;
      if (stamp_q[0] - last_acc_cyc != 2) begin
        n_fails++;
        $display("FAIL single_latency: got %0d cycles required 2", stamp_q[0] - last_acc_cyc);
      end
    end
    n_checks++; if (gap_errs != 0) begin n_fails++; $display("FAIL single_gaps: got %0d required 0", gap_errs); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL single_idle_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL single_idle_in_ready: got %b required 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int bp0;
    int gap_errs;
    bp0 = backpressure;
    gap_errs = 0;
    fork
      begin
        send_pairs(1, 0, 16);
        send_pairs(2, 0, 16);
        send_pairs(3, 0, 16);
      end
      collect(96, 0, 400);
    join
    n_checks++; if (cap_q.size() != 96) begin n_fails++; $display("FAIL b2b_count: got %0d required 96", cap_q.size()); end
    for (int i = 0; i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_sample(i / 32 + 1, i % 32)) begin
        n_fails++;
        $display("FAIL b2b_sample[%0d]: got %h required %h", i, cap_q[i], exp_sample(i / 32 + 1, i % 32));
      end
      if (i > 0 && stamp_q[i] - stamp_q[i-1] != 1) gap_errs++;
    end
    n_checks++; if (gap_errs != 0) begin n_fails++; $display("FAIL b2b_gaps: got %0d required 0", gap_errs); end
    n_checks++; if (backpressure - bp0 == 0) begin n_fails++; $display("FAIL b2b_in_ready_drop: got 0 stalled cycles required >0"); end
  endtask

  task automatic test_stalls;
    fork
      begin
        send_pairs(1, 0, 16);
        send_pairs(2, 0, 16);
      end
      collect(64, 50, 1000);
    join
    n_checks++; if (cap_q.size() != 64) begin n_fails++; $display("FAIL stall_count: got %0d required 64", cap_q.size()); end
    for (int i = 0; i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_sample(i / 32 + 1, i % 32)) begin
        n_fails++;
        $display("FAIL stall_sample[%0d]: got %h required %h", i, cap_q[i], exp_sample(i / 32 + 1, i % 32));
      end
    end
    n_checks++; if (hold_errs != 0) begin n_fails++; $display("FAIL stall_hold: got %0d changes required 0", hold_errs); end
  endtask

  task automatic test_reset_mid;
    // reset after half a frame has been written
    send_pairs(3, 0, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL rstfill_out_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL rstfill_in_ready: got %b required 1", bus.in_ready); end
    // reset in the middle of a drain
    fork
      send_pairs(0, 0, 16);
      collect(13, 0, 200);
    join
    for (int i = 0; i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_sample(0, i)) begin
        n_fails++;
        $display("FAIL rstdrain_pre[%0d]: got %h required %h", i, cap_q[i], exp_sample(0, i));
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL rstdrain_out_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fails++; $display("FAIL rstdrain_out_last: got %b required 0", bus.out_last); end
    n_checks++; if (bus.out_index !== 5'd0) begin n_fails++; $display("FAIL rstdrain_out_index: got %0d required 0", bus.out_index); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL rstdrain_in_ready: got %b required 1", bus.in_ready); end
    // fresh frame after reset
    fork
      send_pairs(2, 0, 16);
      collect(32, 0, 200);
    join
    n_checks++; if (cap_q.size() != 32) begin n_fails++; $display("FAIL rst_fresh_count: got %0d required 32", cap_q.size()); end
    for (int i = 0; i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_sample(2, i)) begin
        n_fails++;
        $display("FAIL rst_fresh_sample[%0d]: got %h required %h", i, cap_q[i], exp_sample(2, i));
      end
    end
  endtask

  task automatic test_extremes;
    fork
      begin
        send_pairs(4, 0, 16);
        send_pairs(4, 0, 16);
      end
      collect(64, 0, 300);
    join
    n_checks++; if (cap_q.size() != 64) begin n_fails++; $display("FAIL extreme_count: got %0d required 64", cap_q.size()); end
    for (int i = 0; i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_sample(4, i % 32)) begin
        n_fails++;
        $display("FAIL extreme_sample[%0d]: got %h required %h", i, cap_q[i], exp_sample(4, i % 32));
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_up_re  = '0;
    bus.in_up_im  = '0;
    bus.in_l_re   = '0;
    bus.in_l_im   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stalls();
    test_reset_mid();
    test_extremes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
